// File: rtl/jtcop_snd_romcache.sv
// jtcop_snd_romcache
// Direct-mapped read cache between the sound CPU ROM port and the SDRAM
// sound-ROM slot. Holds 2^AW lines of 32 bits; a miss fetches one whole line
// over a req/ok handshake. The tag includes the ROM bank bit, so a bank
// switch never returns bytes from the other bank.
module jtcop_snd_romcache #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_cs,
    input  logic        bank,
    input  logic        flush,
    output logic [7:0]  cpu_data,
    output logic        cpu_ok,
    output logic [14:0] sdram_addr,
    output logic        sdram_req,
    input  logic [31:0] sdram_data,
    input  logic        sdram_ok
);

    localparam int TW    = 15 - AW;
    localparam int LINES = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t           state;

    logic [31:0]      line_ram [LINES];
    logic [TW-1:0]    tag_ram  [LINES];
    logic [LINES-1:0] valid;

    logic [AW-1:0]    index;
    logic [TW-1:0]    tag;
    logic [31:0]      line_rd;
    logic             lookup_hit;
    logic [7:0]       sel_byte;

    logic [15:0]      addr_l;
    logic             bank_l;
    logic             hit_l;
    logic             kill;
    logic [31:0]      fill_data;
    logic [AW-1:0]    fill_index;
    logic [TW-1:0]    fill_tag;

    assign index      = cpu_addr[AW+1:2];
    assign tag        = {bank, cpu_addr[15:AW+2]};
    assign fill_index = sdram_addr[AW-1:0];
    assign fill_tag   = sdram_addr[14:AW];

    // Lookup of the current CPU address: read line and tag, compare, pick byte
    always_comb begin
        line_rd    = line_ram[index];
        lookup_hit = valid[index] && (tag_ram[index] == tag);
        sel_byte   = 8'h00;
        case (cpu_addr[1:0])
            2'd0: sel_byte = line_rd[7:0];
            2'd1: sel_byte = line_rd[15:8];
            2'd2: sel_byte = line_rd[23:16];
            2'd3: sel_byte = line_rd[31:24];
            default: sel_byte = 8'h00;
        endcase
    end

    // The qualifier is only true while the registered lookup still matches
    // the live address and bank, so any change drops it in the same cycle
    assign cpu_ok = cpu_cs & hit_l & (cpu_addr == addr_l) & (bank == bank_l)
                  & (state == IDLE);

    // Line and tag storage are written only from the WRITE state; they carry
    // no reset because the valid vector alone decides whether they are used
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE) begin
            line_ram[fill_index] <= fill_data;
            tag_ram[fill_index]  <= fill_tag;
        end
    end

    // Control FSM: lookup in IDLE, hold the request in FILL, commit in WRITE.
    // A flush during FILL arms kill so the in-flight line is stored but not
    // marked valid; a flush during WRITE simply overrides the valid-set, so
    // WRITE can always clear kill without leaking it into the next fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            kill       <= 1'b0;
            addr_l     <= 16'h0000;
            bank_l     <= 1'b0;
            hit_l      <= 1'b0;
            cpu_data   <= 8'h00;
            fill_data  <= 32'h0000_0000;
            sdram_addr <= 15'h0000;
            sdram_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_l   <= cpu_addr;
                    bank_l   <= bank;
                    hit_l    <= lookup_hit & ~flush;
                    cpu_data <= sel_byte;
                    if (cpu_cs && !lookup_hit) begin
                        sdram_addr <= {bank, cpu_addr[15:2]};
                        sdram_req  <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (sdram_ok) begin
                        fill_data <= sdram_data;
                        sdram_req <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (!kill && !flush) begin
                        valid[fill_index] <= 1'b1;
                    end
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    sdram_req <= 1'b0;
                end
            endcase
            if (flush) begin
                valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtcop_snd_romcache.sv
// Self-checking bench for jtcop_snd_romcache: an SDRAM model answers each
// request after a fixed delay and logs the requested line addresses; tests
// queue the expected bytes and compare them when cpu_ok is seen.
module tb_jtcop_snd_romcache;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_cs;
    logic        bank;
    logic        flush;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic [14:0] sdram_addr;
    logic        sdram_req;
    logic [31:0] sdram_data;
    logic        sdram_ok;

    logic        model_en;
    logic        model_ok;
    logic [31:0] model_data;
    logic        manual_ok;
    logic [31:0] manual_data;

    int errors;
    int checks;

    logic [7:0]  exp_q[$];
    logic [14:0] fetch_q[$];

    assign sdram_ok   = model_ok | manual_ok;
    assign sdram_data = manual_ok ? manual_data : model_data;

    jtcop_snd_romcache #(.AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_cs     (cpu_cs),
        .bank       (bank),
        .flush      (flush),
        .cpu_data   (cpu_data),
        .cpu_ok     (cpu_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_data (sdram_data),
        .sdram_ok   (sdram_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the sound ROM as seen by the SDRAM model
    function automatic logic [31:0] line_of(input logic [14:0] la);
        if (la == 15'h2000) return 32'h4433_2211;
        return {la[7:0] ^ 8'hC3, 1'b0, la[14:8], la[7:0] ^ 8'h3C, la[7:0]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [15:0] a, input logic b);
        logic [31:0] l;
        l = line_of({b, a[15:2]});
        case (a[1:0])
            2'd0: return l[7:0];
            2'd1: return l[15:8];
            2'd2: return l[23:16];
            default: return l[31:24];
        endcase
    endfunction

    // SDRAM model: answers a request with a one-cycle ok five cycles after it is seen
    initial begin
        int  cnt;
        bit  busy;
        logic [14:0] req_addr;
        model_ok   = 1'b0;
        model_data = 32'h0;
        busy       = 1'b0;
        cnt        = 0;
        req_addr   = 15'h0;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                model_ok = 1'b0;
                busy     = 1'b0;
            end else if (!model_en) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (sdram_req) begin
                    busy     = 1'b1;
                    cnt      = 0;
                    req_addr = sdram_addr;
                    fetch_q.push_back(sdram_addr);
                end
            end else if (!sdram_req) begin
                busy = 1'b0;
            end else begin
                cnt++;
                if (cnt == 5) begin
                    model_ok   = 1'b1;
                    model_data = line_of(req_addr);
                end
            end
        end
    end

    // Presents an address with chip select and waits for cpu_ok; cyc=-1 on timeout
    task automatic cpu_read(input logic [15:0] a, input logic b, input int budget,
                            output logic [7:0] d, output int cyc);
        cpu_addr = a;
        bank     = b;
        cpu_cs   = 1'b1;
        cyc      = -1;
        d        = 8'h00;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (cpu_ok) begin
                cyc = i;
                d   = cpu_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_cs = 1'b1;
        cpu_addr = 16'h8001;
        repeat (3) @(negedge clk);
        checks++;
        if (sdram_req !== 1'b0 || cpu_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req=%b ok=%b expected req=0 ok=0", sdram_req, cpu_ok);
        end
        checks++;
        if (cpu_data !== 8'h00 || sdram_addr !== 15'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data: data=%h addr=%h expected 00/0000", cpu_data, sdram_addr);
        end
        cpu_cs = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_miss();
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        exp_q.push_back(exp_byte(16'h8001, 1'b0));
        cpu_read(16'h8001, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e) begin
            errors++;
            $display("[TB] FAIL first_miss_data: got %h (cyc %0d) expected %h", d, cyc, e);
        end
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("[TB] FAIL miss_latency: got %0d cycles expected 9", cyc);
        end
        checks++;
        if (fetch_q.size() != 1 || fetch_q[0] !== 15'h2000) begin
            errors++;
            $display("[TB] FAIL first_miss_fetch: fetches=%0d expected one at 2000", fetch_q.size());
        end
        fetch_q.delete();
    endtask

    task automatic test_hits();
        logic [15:0] addrs[3] = '{16'h8000, 16'h8002, 16'h8003};
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_byte(addrs[i], 1'b0));
            cpu_read(addrs[i], 1'b0, 20, d, cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != 1 || d !== e) begin
                errors++;
                $display("[TB] FAIL hit_%h: got %h after %0d cycles expected %h after 1", addrs[i], d, cyc, e);
            end
        end
        checks++;
        if (fetch_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL hit_no_fetch: fetches=%0d expected 0", fetch_q.size());
        end
        fetch_q.delete();
    endtask

    task automatic test_bank();
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        exp_q.push_back(exp_byte(16'h8001, 1'b1));
        cpu_read(16'h8001, 1'b1, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h6000) begin
            errors++;
            $display("[TB] FAIL bank1_miss: got %h fetches=%0d expected %h one fetch at 6000", d, fetch_q.size(), e);
        end
        fetch_q.delete();
        exp_q.push_back(exp_byte(16'h8001, 1'b0));
        cpu_read(16'h8001, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h2000) begin
            errors++;
            $display("[TB] FAIL bank0_reload: got %h fetches=%0d expected %h one fetch at 2000", d, fetch_q.size(), e);
        end
        fetch_q.delete();
    endtask

    task automatic test_evict();
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        exp_q.push_back(exp_byte(16'h8040, 1'b0));
        cpu_read(16'h8040, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h2010) begin
            errors++;
            $display("[TB] FAIL evict_fill: got %h fetches=%0d expected %h one fetch at 2010", d, fetch_q.size(), e);
        end
        fetch_q.delete();
        exp_q.push_back(exp_byte(16'h8000, 1'b0));
        cpu_read(16'h8000, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h2000) begin
            errors++;
            $display("[TB] FAIL evict_return: got %h fetches=%0d expected %h one fetch at 2000", d, fetch_q.size(), e);
        end
        fetch_q.delete();
    endtask

    task automatic test_cs_low();
        bit any_ok;
        any_ok = 1'b0;
        cpu_cs = 1'b0;
        cpu_addr = 16'h0100;
        bank = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ok) any_ok = 1'b1;
            cpu_addr = cpu_addr + 16'h0404;
        end
        checks++;
        if (any_ok || fetch_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL cs_low: ok_seen=%b fetches=%0d expected 0/0", any_ok, fetch_q.size());
        end
        fetch_q.delete();
    endtask

    task automatic test_flush_fill();
        logic [7:0] e;
        bit seen_req;
        bit got;
        exp_q.push_back(exp_byte(16'hC010, 1'b0));
        cpu_addr = 16'hC010;
        bank = 1'b0;
        cpu_cs = 1'b1;
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_req) begin
                seen_req = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_req) begin
            errors++;
            $display("[TB] FAIL flush_req: req=%b expected 1", sdram_req);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cpu_ok) begin
                got = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!got || cpu_data !== e) begin
            errors++;
            $display("[TB] FAIL flush_data: ok=%b data=%h expected 1/%h", got, cpu_data, e);
        end
        checks++;
        if (fetch_q.size() != 2 || fetch_q[0] !== 15'h3004 || fetch_q[1] !== 15'h3004) begin
            errors++;
            $display("[TB] FAIL flush_refetch: fetches=%0d expected two at 3004", fetch_q.size());
        end
        fetch_q.delete();
    endtask

    task automatic test_flush_idle();
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.push_back(exp_byte(16'hC012, 1'b0));
        cpu_read(16'hC012, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL flush_idle: got %h fetches=%0d expected %h one fetch", d, fetch_q.size(), e);
        end
        fetch_q.delete();
    endtask

    task automatic test_rst_mid_fill();
        logic [7:0] d;
        logic [7:0] e;
        int cyc;
        bit seen_req;
        model_en = 1'b0;
        cpu_addr = 16'h1234;
        bank = 1'b0;
        cpu_cs = 1'b1;
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_req) begin
                seen_req = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        cpu_cs = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen_req || sdram_req !== 1'b0 || cpu_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_fill: seen=%b req=%b ok=%b expected 1/0/0", seen_req, sdram_req, cpu_ok);
        end
        rst = 1'b0;
        @(negedge clk);
        manual_data = 32'hDEAD_BEEF;
        manual_ok = 1'b1;
        @(negedge clk);
        manual_ok = 1'b0;
        @(negedge clk);
        model_en = 1'b1;
        exp_q.push_back(exp_byte(16'h1234, 1'b0));
        cpu_read(16'h1234, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h048D) begin
            errors++;
            $display("[TB] FAIL stale_ok: got %h fetches=%0d expected %h one fetch at 048D", d, fetch_q.size(), e);
        end
        fetch_q.delete();
        exp_q.push_back(exp_byte(16'hC010, 1'b0));
        cpu_read(16'hC010, 1'b0, 40, d, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || d !== e || fetch_q.size() != 1 || fetch_q[0] !== 15'h3004) begin
            errors++;
            $display("[TB] FAIL rst_invalid: got %h fetches=%0d expected %h one fetch at 3004", d, fetch_q.size(), e);
        end
        fetch_q.delete();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        cpu_addr    = 16'h0000;
        cpu_cs      = 1'b0;
        bank        = 1'b0;
        flush       = 1'b0;
        model_en    = 1'b1;
        manual_ok   = 1'b0;
        manual_data = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_miss();
        test_hits();
        test_bank();
        test_evict();
        test_cs_low();
        test_flush_fill();
        test_flush_idle();
        test_rst_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
